// File: rtl/thermo_pool_pkg.sv
// Shared types and widths for the thermometer-coded pooling datapath.
// Downstream thermometer stages reuse these definitions.
package thermo_pool_pkg;

  localparam int THERMO_W = 15;
  localparam int PIX_W    = 4;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } pool_state_e;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_MIN = 1'b1
  } pool_mode_e;

  // On thermometer codes, OR is max and AND is min.
  function automatic logic [THERMO_W-1:0] pool_fold(
    input logic [THERMO_W-1:0] acc,
    input logic [THERMO_W-1:0] thermo,
    input pool_mode_e          mode
  );
    return (mode == MODE_MIN) ? (acc & thermo) : (acc | thermo);
  endfunction

endpackage

// File: rtl/pix_to_thermo.sv
// Combinational pixel-to-thermometer encoder: bit i is set when the pixel exceeds i.
// Kept standalone so later thermometer stages can share it.
module pix_to_thermo
  import thermo_pool_pkg::*;
(
  input  logic [PIX_W-1:0]    i_pix,
  output logic [THERMO_W-1:0] o_thermo
);

  always_comb begin
    o_thermo = '0;
    for (int i = 0; i < THERMO_W; i++) begin
      o_thermo[i] = (i_pix > PIX_W'(i));
    end
  end

endmodule

// File: rtl/thermo_pool_acc.sv
// Pools WINDOW pixels into one thermometer-coded max or min, then holds the
// result under a valid/ready handshake before accepting the next window.
module thermo_pool_acc
  import thermo_pool_pkg::*;
#(
  parameter int WINDOW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PIX_W-1:0]    in_pixel,
  input  logic                pool_mode,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [THERMO_W-1:0] out_thermo
);

  localparam int                CNT_W      = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0]  CNT_PENULT = CNT_W'(WINDOW - 1);

  pool_state_e           r_state;
  pool_state_e           w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [THERMO_W-1:0]   r_acc;
  pool_mode_e            r_mode;
  logic                  r_rdy_arm;
  logic [THERMO_W-1:0]   w_thermo;
  logic                  w_take;
  logic                  w_last;

  pix_to_thermo u_enc (
    .i_pix    (in_pixel),
    .o_thermo (w_thermo)
  );

  // Flush wins over a simultaneous pixel, so that pixel is dropped.
  assign w_take = in_valid & in_ready & ~flush;
  assign w_last = w_take & (r_cnt == CNT_PENULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: if (w_last)    w_state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready) w_state_nxt = ST_ACCUM;
      default:                 w_state_nxt = ST_ACCUM;
    endcase
  end

  // in_ready stays low until the first edge after reset release.
  always_comb begin
    in_ready   = (r_state == ST_ACCUM) & r_rdy_arm;
    out_valid  = (r_state == ST_HOLD);
    out_thermo = out_valid ? r_acc : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_arm <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mode    <= MODE_MAX;
    end else begin
      r_rdy_arm <= 1'b1;
      case (r_state)
        ST_ACCUM: begin
          if (flush) begin
            r_cnt <= '0;
            r_acc <= '0;
          end else if (w_take) begin
            if (r_cnt == '0) begin
              r_acc  <= w_thermo;
              r_mode <= pool_mode_e'(pool_mode);
            end else begin
              r_acc <= pool_fold(r_acc, w_thermo, r_mode);
            end
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_cnt <= '0;
            r_acc <= '0;
          end
        end
        default: begin
          r_cnt <= '0;
          r_acc <= '0;
        end
      endcase
    end
  end

endmodule
